// File: rtl/puf_soc_ro_cmp.sv
// RO PUF measurement block: enables an RO pair, settles, counts rising edges of both over a window, compares.
// Optional PUF_SOC_RO_CNT_OUT_EN exposes the final edge counts as o_cnt_a / o_cnt_b.
module puf_soc_ro_cmp #(
  parameter int PUF_LENGTH = 16,
  parameter int IDX_W      = 4,
  parameter int WIN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [IDX_W-1:0]      i_sel_a,
  input  logic [IDX_W-1:0]      i_sel_b,
  input  logic [WIN_W-1:0]      i_win_len,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic                  o_resp,
  output logic                  o_tie,
  output logic                  o_err,
  output logic [PUF_LENGTH-1:0] o_puf_en,
  input  logic [PUF_LENGTH-1:0] i_puf_ro
`ifdef PUF_SOC_RO_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0]      o_cnt_a,
  output logic [CNT_W-1:0]      o_cnt_b
`endif
);

  localparam int ST_W = $clog2(SETTLE_CYC + 1);
  localparam logic [IDX_W:0] PUF_LEN_L = (IDX_W+1)'(PUF_LENGTH);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, CMP} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      sel_a_q, sel_b_q;
  logic [WIN_W-1:0]      win_len_q;
  logic [ST_W-1:0]       settle_cnt;
  logic [WIN_W-1:0]      win_cnt;
  logic [CNT_W-1:0]      cnt_a, cnt_b;
  logic                  err_q;
  logic                  accept, legal, settle_done, win_done;
  logic                  ro_a_p0, ro_a_p1, ro_a_p2;
  logic                  ro_b_p0, ro_b_p1, ro_b_p2;
  logic                  rise_a, rise_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != {CNT_W{1'b1}}))
      return c + CNT_W'(1);
    return c;
  endfunction

  function automatic logic [PUF_LENGTH-1:0] pair_mask(input logic [IDX_W-1:0] a,
                                                      input logic [IDX_W-1:0] b);
    logic [PUF_LENGTH-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    m[b] = 1'b1;
    return m;
  endfunction

  assign legal = (i_sel_a != i_sel_b) &&
                 ({1'b0, i_sel_a} < PUF_LEN_L) &&
                 ({1'b0, i_sel_b} < PUF_LEN_L) &&
                 (i_win_len != '0);

  assign settle_done = (settle_cnt == ST_W'(SETTLE_CYC - 1));
  assign win_done    = (win_cnt == (win_len_q - WIN_W'(1)));

  // Start is also refused during the o_valid cycle, when o_busy is still high
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !o_busy) begin
          accept  = 1'b1;
          state_d = legal ? SETTLE : CMP;
        end
      end
      SETTLE:  if (settle_done) state_d = COUNT;
      COUNT:   if (win_done) state_d = CMP;
      CMP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Stage p0..p1: two-flop synchronizer on the selected RO lines; p2: edge-detect history
  always_ff @(posedge i_clk) begin
    if (state_q == SETTLE) begin
      ro_a_p0 <= 1'b0;
      ro_a_p1 <= 1'b0;
      ro_a_p2 <= 1'b0;
      ro_b_p0 <= 1'b0;
      ro_b_p1 <= 1'b0;
      ro_b_p2 <= 1'b0;
    end else begin
      ro_a_p0 <= i_puf_ro[sel_a_q];
      ro_a_p1 <= ro_a_p0;
      ro_a_p2 <= ro_a_p1;
      ro_b_p0 <= i_puf_ro[sel_b_q];
      ro_b_p1 <= ro_b_p0;
      ro_b_p2 <= ro_b_p1;
    end
  end

  assign rise_a = ro_a_p1 & ~ro_a_p2;
  assign rise_b = ro_b_p1 & ~ro_b_p2;

  always_ff @(posedge i_clk) begin
    if (accept) begin
      sel_a_q   <= i_sel_a;
      sel_b_q   <= i_sel_b;
      win_len_q <= i_win_len;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_resp     <= 1'b0;
      o_tie      <= 1'b0;
      o_err      <= 1'b0;
      o_puf_en   <= '0;
      err_q      <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
    end else begin
      o_valid <= (state_q == CMP);

      if (accept)
        o_busy <= 1'b1;
      else if (o_valid)
        o_busy <= 1'b0;

      if (accept)
        err_q <= ~legal;

      if (accept && legal)
        o_puf_en <= pair_mask(i_sel_a, i_sel_b);
      else if ((state_q == COUNT) && win_done)
        o_puf_en <= '0;

      settle_cnt <= (state_q == SETTLE) ? settle_cnt + ST_W'(1) : '0;
      win_cnt    <= (state_q == COUNT)  ? win_cnt + WIN_W'(1)   : '0;

      if (accept || (state_q == SETTLE)) begin
        cnt_a <= '0;
        cnt_b <= '0;
      end else if (state_q == COUNT) begin
        cnt_a <= sat_inc(cnt_a, rise_a);
        cnt_b <= sat_inc(cnt_b, rise_b);
      end

      if (state_q == CMP) begin
        o_err  <= err_q;
        o_resp <= ~err_q && (cnt_a > cnt_b);
        o_tie  <= ~err_q && (cnt_a == cnt_b);
      end
    end
  end

`ifdef PUF_SOC_RO_CNT_OUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_a <= '0;
      o_cnt_b <= '0;
    end else if (state_q == CMP) begin
      o_cnt_a <= cnt_a;
      o_cnt_b <= cnt_b;
    end
  end
`endif

endmodule

// File: tb/tb_puf_soc_ro_cmp.sv
// Scoreboard bench for puf_soc_ro_cmp: a 16-bit-counter instance and a 4-bit-counter instance share stimulus.
module tb_puf_soc_ro_cmp;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [3:0]  i_sel_a, i_sel_b;
  logic [15:0] i_win_len;
  logic [15:0] i_puf_ro;

  logic        o_busy, o_valid, o_resp, o_tie, o_err;
  logic [15:0] o_puf_en;
  logic        s_busy, s_valid, s_resp, s_tie, s_err;
  logic [15:0] s_puf_en;
`ifdef PUF_SOC_RO_CNT_OUT_EN
  logic [15:0] o_cnt_a, o_cnt_b;
  logic [3:0]  s_cnt_a, s_cnt_b;
`endif

  puf_soc_ro_cmp #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_sel_a(i_sel_a), .i_sel_b(i_sel_b),
    .i_win_len(i_win_len), .o_busy(o_busy), .o_valid(o_valid), .o_resp(o_resp), .o_tie(o_tie),
    .o_err(o_err), .o_puf_en(o_puf_en), .i_puf_ro(i_puf_ro)
`ifdef PUF_SOC_RO_CNT_OUT_EN
    , .o_cnt_a(o_cnt_a), .o_cnt_b(o_cnt_b)
`endif
  );

  puf_soc_ro_cmp #(.CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_sel_a(i_sel_a), .i_sel_b(i_sel_b),
    .i_win_len(i_win_len), .o_busy(s_busy), .o_valid(s_valid), .o_resp(s_resp), .o_tie(s_tie),
    .o_err(s_err), .o_puf_en(s_puf_en), .i_puf_ro(i_puf_ro)
`ifdef PUF_SOC_RO_CNT_OUT_EN
    , .o_cnt_a(s_cnt_a), .o_cnt_b(s_cnt_b)
`endif
  );

  typedef struct {
    int vcyc;
    bit resp, tie, err, sresp, stie;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   tick   = 0;
  int   per[16];
  bit   mon_on = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // RO waveforms change on the falling clock edge, well away from the sampling edge
  initial begin
    i_puf_ro = '0;
    forever @(negedge clk) begin
      tick++;
      for (int i = 0; i < 16; i++)
        i_puf_ro[i] = (per[i] != 0) && ((tick % per[i]) < (per[i] / 2));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever @(negedge clk) begin
      if (mon_on && (o_valid === 1'b1)) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("valid_cycle", cyc, e.vcyc);
          chk("resp", o_resp, e.resp);
          chk("tie", o_tie, e.tie);
          chk("err", o_err, e.err);
          chk("busy_at_valid", o_busy, 1);
          chk("sat_valid", s_valid, 1);
          chk("sat_resp", s_resp, e.sresp);
          chk("sat_tie", s_tie, e.stie);
          chk("sat_err", s_err, e.err);
          @(negedge clk);
          chk("busy_after_valid", o_busy, 0);
          chk("valid_one_cycle", o_valid, 0);
        end
      end
    end
  end

  // The start pulse is presented one cycle before the edge that accepts it; latency counts from that edge
  task automatic run(input int a, input int b, input int win, input bit legal,
                     input bit r, input bit t, input bit sr, input bit st, input bit pulse);
    exp_t        e;
    int          acc, n;
    bit          en_seen;
    logic [15:0] mask;
    @(negedge clk);
    i_sel_a   = 4'(a);
    i_sel_b   = 4'(b);
    i_win_len = 16'(win);
    i_start   = 1'b1;
    @(posedge clk);
    #1;
    acc     = cyc;
    i_start = 1'b0;
    e.vcyc  = acc + (legal ? (1 + 8 + win) : 1);
    e.resp  = r;
    e.tie   = t;
    e.err   = !legal;
    e.sresp = sr;
    e.stie  = st;
    q.push_back(e);
    mask    = legal ? ((16'd1 << a) | (16'd1 << b)) : 16'd0;
    en_seen = 0;
    n       = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (o_puf_en != 0) en_seen = 1;
      if (legal && cyc == acc + 1) chk("en_settle", o_puf_en, mask);
      if (legal && cyc == acc + 9 + win / 2) begin
        chk("en_count", o_puf_en, mask);
        if (pulse) begin
          i_start = 1'b1;
          i_sel_a = 4'(b);
          i_sel_b = 4'(a);
        end
      end
      if (cyc == acc + 10 + win / 2) i_start = 1'b0;
    end
    if (n >= 400) chk("timeout", 1, 0);
    if (!legal) chk("en_illegal", en_seen, 0);
    @(negedge clk);
    @(negedge clk);
    chk("en_off", o_puf_en, 0);
    chk("resp_hold", o_resp, r);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 16; i++) per[i] = 0;
    i_rst = 1'b1; i_start = 1'b1; i_sel_a = 4'd3; i_sel_b = 4'd7; i_win_len = 16'd10;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_outs", {o_resp, o_tie, o_err}, 0);
    chk("rst_en", o_puf_en, 16'h0000);
    i_rst = 1'b0; i_start = 1'b0;
    @(negedge clk);
    chk("rst_release_valid", o_valid, 0);
    mon_on = 1;

    // A faster than B, with a stray start mid-window
    per[3] = 4; per[7] = 6;
    run(3, 7, 100, 1, 1, 0, 0, 1, 1);
    // Illegal pair right after a resp=1 result
    run(5, 5, 10, 0, 0, 0, 0, 0, 0);
    // B faster than A
    run(7, 3, 100, 1, 0, 0, 0, 1, 0);
    // Equal frequency and phase
    per[0] = 4; per[15] = 4;
    run(0, 15, 40, 1, 0, 1, 0, 1, 0);
    // Only A saturates the 4-bit counter: 50 vs ~5 edges
    per[1] = 2; per[2] = 20;
    run(1, 2, 100, 1, 1, 0, 1, 0, 0);
    // Zero-length window
    run(1, 2, 0, 0, 0, 0, 0, 0, 0);
    // Both saturate
    per[4] = 2;
    run(1, 4, 100, 1, 0, 1, 0, 1, 0);

    // Reset in the middle of COUNT aborts without a response
    @(negedge clk);
    i_sel_a = 4'd3; i_sel_b = 4'd7; i_win_len = 16'd100; i_start = 1'b1;
    @(posedge clk);
    #1;
    acc     = cyc;
    i_start = 1'b0;
    while (cyc < acc + 40) @(negedge clk);
    chk("abort_en_before", o_puf_en, 16'h0088);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("abort_en", o_puf_en, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_tie", o_tie, 0);
    repeat (150) @(negedge clk);

    run(3, 7, 100, 1, 1, 0, 0, 1, 0);
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
